// File: rtl/sprite_scroller.sv
// sprite_scroller: animates NUM_SPRITES copies of one ROM sprite scrolling right-to-left,
// respawning each copy at the right edge at a pseudo-random height. Provides hit flags for
// the draw and frame-buffer write coordinates and the sprite-ROM address for the write side.
module sprite_scroller #(
  parameter int NUM_SPRITES     = 3,
  parameter int SPRITE_W        = 92,
  parameter int SPRITE_H        = 27,
  parameter int BASE_ADDR       = 44420,
  parameter int ADDR_W          = 18,
  parameter int SCREEN_W        = 640,
  parameter int SPAWN_GAP       = 213,
  parameter int Y_MIN           = 40,
  parameter int Y_RANGE_BITS    = 6,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic              Clk50,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              enable,
  input  logic [9:0]        WriteX,
  input  logic [9:0]        WriteY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              sprite_on_dr,
  output logic              sprite_on_wr,
  output logic [ADDR_W-1:0] address,
  output logic [2:0]        hit_idx
);

  // X positions are kept wider than the screen so that the staggered start positions
  // of later sprites (well beyond the right edge) are held without wrapping.
  localparam int POS_W  = 13;
  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic signed [POS_W-1:0] LEFT_LIMIT = POS_W'(-SPRITE_W);
  localparam logic signed [POS_W-1:0] RESPAWN_X  = POS_W'(SCREEN_W);
  localparam logic signed [POS_W-1:0] WIDTH_S    = POS_W'(SPRITE_W);
  localparam logic [10:0]             HEIGHT_U   = 11'(SPRITE_H);
  localparam logic [STEP_W-1:0]       STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [ADDR_W-1:0]       BASE_A     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]       WIDTH_A    = ADDR_W'(SPRITE_W);
  localparam logic [9:0]              Y_BASE     = 10'(Y_MIN);

  logic signed [POS_W-1:0] pos_x    [NUM_SPRITES];
  logic [9:0]              pos_y    [NUM_SPRITES];
  logic [STEP_W-1:0]       step_cnt [NUM_SPRITES];
  logic [15:0]             lfsr;
  logic                    lfsr_fb;

  logic [NUM_SPRITES-1:0]  wr_hits;
  logic [NUM_SPRITES-1:0]  dr_hits;
  logic                    wr_hit;
  logic [2:0]              wr_sel;
  logic signed [POS_W-1:0] sel_x;
  logic [9:0]              sel_y;
  logic signed [POS_W-1:0] write_x_s;
  logic [9:0]              row;
  logic signed [POS_W-1:0] col;
  logic [ADDR_W-1:0]       wr_addr;

  // Box test with the coordinate zero-extended into the signed position domain, so a
  // sprite partly off the left edge is clipped rather than wrapping to the right edge.
  function automatic logic in_box(input logic signed [POS_W-1:0] px,
                                  input logic [9:0] py,
                                  input logic [9:0] x,
                                  input logic [9:0] y);
    logic signed [POS_W-1:0] sx;
    logic [10:0] y_ext;
    logic [10:0] y_top;
    logic [10:0] y_end;
    sx    = signed'({{(POS_W-10){1'b0}}, x});
    y_ext = {1'b0, y};
    y_top = {1'b0, py};
    y_end = y_top + HEIGHT_U;
    in_box = (sx >= px) && (sx < px + WIDTH_S) && (y_ext >= y_top) && (y_ext < y_end);
  endfunction

  // 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting towards bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Motion state: reset placement, LFSR advance on every frame, paced steps and respawn.
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      lfsr <= 16'hACE1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x[i]    <= POS_W'(SCREEN_W + i * SPAWN_GAP);
        pos_y[i]    <= 10'(Y_MIN + ((16 * i) % (1 << Y_RANGE_BITS)));
        step_cnt[i] <= '0;
      end
    end else if (frame_tick) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
      if (enable) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (step_cnt[i] == STEP_LAST) begin
            step_cnt[i] <= '0;
            if (pos_x[i] == LEFT_LIMIT) begin
              pos_x[i] <= RESPAWN_X;
              pos_y[i] <= Y_BASE + 10'(lfsr[i +: Y_RANGE_BITS]);
            end else begin
              pos_x[i] <= pos_x[i] - POS_W'(1);
            end
          end else begin
            step_cnt[i] <= step_cnt[i] + STEP_W'(1);
          end
        end
      end
    end
  end

  // Per-sprite hit flags for both coordinate pairs against the current positions.
  always_comb begin
    wr_hits = '0;
    dr_hits = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      wr_hits[i] = in_box(pos_x[i], pos_y[i], WriteX, WriteY);
      dr_hits[i] = in_box(pos_x[i], pos_y[i], DrawX, DrawY);
    end
  end

  // Priority pick for the write side: scanning downwards leaves the lowest index hit.
  always_comb begin
    wr_hit = 1'b0;
    wr_sel = '0;
    sel_x  = '0;
    sel_y  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (wr_hits[i]) begin
        wr_hit = 1'b1;
        wr_sel = 3'(i);
        sel_x  = pos_x[i];
        sel_y  = pos_y[i];
      end
    end
  end

  assign sprite_on_dr = |dr_hits;

  // On a hit row/col are non-negative and bounded by the sprite size, so the offset
  // fits well inside the ROM address width.
  assign write_x_s = signed'({{(POS_W-10){1'b0}}, WriteX});
  assign row       = WriteY - sel_y;
  assign col       = write_x_s - sel_x;
  assign wr_addr   = BASE_A + ADDR_W'(row) * WIDTH_A + ADDR_W'(unsigned'(col));

  // Registered write-side outputs, one cycle behind the write coordinate.
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      sprite_on_wr <= 1'b0;
      address      <= BASE_A;
      hit_idx      <= '0;
    end else if (wr_hit) begin
      sprite_on_wr <= 1'b1;
      address      <= wr_addr;
      hit_idx      <= wr_sel;
    end else begin
      sprite_on_wr <= 1'b0;
      address      <= BASE_A;
      hit_idx      <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_scroller.sv
// tb_sprite_scroller: drives two scroller instances (single sprite; three overlapping sprites
// at a slower pace) from shared stimulus and compares them with a behavioural model.
module tb_sprite_scroller;

  localparam int BASE = 44420;
  localparam int SW   = 92;
  localparam int SH   = 27;

  logic        clk = 1'b0;
  logic        rst, tick, en;
  logic [9:0]  wx, wy, dx, dy;
  logic        dr_a, wr_a, dr_b, wr_b;
  logic [17:0] addr_a, addr_b;
  logic [2:0]  idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  // Model configuration per instance: sprite count, start stagger, frames per step.
  int ns[2]  = '{1, 3};
  int gap[2] = '{213, 0};
  int fps[2] = '{1, 3};
  int mpx[2][8];
  int mpy[2][8];
  int mcnt[2][8];
  int lfsr;
  bit exp_dr[2];
  bit exp_wr[2];
  int exp_addr[2];
  int exp_idx[2];

  always #5 clk = ~clk;

  sprite_scroller #(.NUM_SPRITES(1)) dut_a (
    .Clk50(clk), .Reset(rst), .frame_tick(tick), .enable(en),
    .WriteX(wx), .WriteY(wy), .DrawX(dx), .DrawY(dy),
    .sprite_on_dr(dr_a), .sprite_on_wr(wr_a), .address(addr_a), .hit_idx(idx_a)
  );

  sprite_scroller #(.NUM_SPRITES(3), .SPAWN_GAP(0), .FRAMES_PER_STEP(3)) dut_b (
    .Clk50(clk), .Reset(rst), .frame_tick(tick), .enable(en),
    .WriteX(wx), .WriteY(wy), .DrawX(dx), .DrawY(dy),
    .sprite_on_dr(dr_b), .sprite_on_wr(wr_b), .address(addr_b), .hit_idx(idx_b)
  );

  // Lowest-index sprite whose box contains (x,y), or -1.
  function automatic int model_hit(int d, int x, int y);
    for (int i = 0; i < ns[d]; i++)
      if (x >= mpx[d][i] && x < mpx[d][i] + SW && y >= mpy[d][i] && y < mpy[d][i] + SH)
        return i;
    return -1;
  endfunction

  function automatic int lfsr_advance(int l);
    int b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  task automatic set_inputs(bit r, bit t, bit e, int x, int y, int ddx, int ddy);
    rst = r; tick = t; en = e;
    wx = 10'(x); wy = 10'(y); dx = 10'(ddx); dy = 10'(ddy);
    for (int d = 0; d < 2; d++) exp_dr[d] = (model_hit(d, ddx, ddy) >= 0);
  endtask

  // Advance one clock and update the model from the values present at that edge.
  task automatic clock_edge();
    int h;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < ns[d]; i++) begin
          mpx[d][i] = 640 + i * gap[d];
          mpy[d][i] = 40 + ((16 * i) % 64);
          mcnt[d][i] = 0;
        end
        exp_wr[d] = 0; exp_addr[d] = BASE; exp_idx[d] = 0;
      end else begin
        h = model_hit(d, int'(wx), int'(wy));
        if (h >= 0) begin
          exp_wr[d] = 1; exp_idx[d] = h;
          exp_addr[d] = BASE + (int'(wy) - mpy[d][h]) * SW + (int'(wx) - mpx[d][h]);
        end else begin
          exp_wr[d] = 0; exp_addr[d] = BASE; exp_idx[d] = 0;
        end
        if (tick && en) begin
          for (int i = 0; i < ns[d]; i++) begin
            if (mcnt[d][i] == fps[d] - 1) begin
              mcnt[d][i] = 0;
              if (mpx[d][i] == -SW) begin
                mpx[d][i] = 640;
                mpy[d][i] = 40 + ((lfsr >> i) & 63);
              end else begin
                mpx[d][i] = mpx[d][i] - 1;
              end
            end else begin
              mcnt[d][i] = mcnt[d][i] + 1;
            end
          end
        end
      end
    end
    if (rst) lfsr = 'hACE1;
    else if (tick) lfsr = lfsr_advance(lfsr);
    #1;
  endtask

  task automatic run_ticks(int n, bit e);
    repeat (n) begin
      set_inputs(0, 1, e, 1023, 1023, 1023, 1023);
      clock_edge();
    end
  endtask

  task automatic test_reset();
    set_inputs(1, 0, 0, 640, 40, 640, 40);
    clock_edge();
    set_inputs(1, 1, 1, 640, 40, 640, 40);
    clock_edge();
    checks++; if (wr_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_on_wr_a got %0d expected 0", wr_a); end
    checks++; if (addr_a !== 18'(BASE)) begin errors++; $display("[TB] FAIL reset_addr_a got %0d expected %0d", addr_a, BASE); end
    checks++; if (idx_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_idx_a got %0d expected 0", idx_a); end
    checks++; if (wr_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_on_wr_b got %0d expected 0", wr_b); end
    checks++; if (addr_b !== 18'(BASE)) begin errors++; $display("[TB] FAIL reset_addr_b got %0d expected %0d", addr_b, BASE); end
    set_inputs(0, 0, 0, 640, 40, 640, 40);
    #1;
    checks++; if (dr_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_dr_corner_a got %0d expected 1", dr_a); end
    checks++; if (dr_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_dr_corner_b got %0d expected 1", dr_b); end
    clock_edge();
    checks++; if (wr_a !== 1'b1) begin errors++; $display("[TB] FAIL t1_on_wr got %0d expected 1", wr_a); end
    checks++; if (addr_a !== 18'(BASE)) begin errors++; $display("[TB] FAIL t1_addr_corner got %0d expected %0d", addr_a, BASE); end
    set_inputs(0, 0, 0, 0, 0, 639, 40);
    #1;
    checks++; if (dr_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_dr_left_a got %0d expected 0", dr_a); end
    clock_edge();
  endtask

  // Write-path corners of the single sprite and priority among the overlapping three.
  task automatic test_write_path();
    int px[6]  = '{731, 732, 640, 641, 645, 650};
    int py[6]  = '{66, 66, 60, 70, 75, 90};
    int aon[6] = '{1, 0, 1, 0, 0, 0};
    int aad[6] = '{46903, BASE, 46260, BASE, BASE, BASE};
    int bon[6] = '{1, 0, 1, 1, 1, 1};
    int bad[6] = '{46903, BASE, 46260, 45709, 46173, 46086};
    int bix[6] = '{0, 0, 0, 1, 1, 2};
    for (int k = 0; k < 6; k++) begin
      set_inputs(0, 0, 0, px[k], py[k], 0, 0);
      clock_edge();
      checks++; if (wr_a !== 1'(aon[k])) begin errors++; $display("[TB] FAIL wr_on_a[%0d] got %0d expected %0d", k, wr_a, aon[k]); end
      checks++; if (addr_a !== 18'(aad[k])) begin errors++; $display("[TB] FAIL wr_addr_a[%0d] got %0d expected %0d", k, addr_a, aad[k]); end
      checks++; if (wr_b !== 1'(bon[k])) begin errors++; $display("[TB] FAIL wr_on_b[%0d] got %0d expected %0d", k, wr_b, bon[k]); end
      checks++; if (addr_b !== 18'(bad[k])) begin errors++; $display("[TB] FAIL wr_addr_b[%0d] got %0d expected %0d", k, addr_b, bad[k]); end
      checks++; if (idx_b !== 3'(bix[k])) begin errors++; $display("[TB] FAIL wr_idx_b[%0d] got %0d expected %0d", k, idx_b, bix[k]); end
    end
  endtask

  // Paused frames must not move sprites; then 9 enabled frames move 9 vs 3 pixels.
  task automatic test_pause();
    int px[4]  = '{640, 639, 637, 630};
    int aon[4] = '{1, 0, 1, 0};
    int aad[4] = '{BASE, BASE, BASE + 6, BASE};
    int bon[4] = '{1, 0, 1, 0};
    run_ticks(100, 0);
    for (int k = 0; k < 2; k++) begin
      set_inputs(0, 0, 0, px[k], 40, 0, 0);
      clock_edge();
      checks++; if (wr_a !== 1'(aon[k])) begin errors++; $display("[TB] FAIL pause_on_a[%0d] got %0d expected %0d", k, wr_a, aon[k]); end
      checks++; if (addr_a !== 18'(aad[k])) begin errors++; $display("[TB] FAIL pause_addr_a[%0d] got %0d expected %0d", k, addr_a, aad[k]); end
      checks++; if (wr_b !== 1'(bon[k])) begin errors++; $display("[TB] FAIL pause_on_b[%0d] got %0d expected %0d", k, wr_b, bon[k]); end
    end
    run_ticks(9, 1);
    for (int k = 2; k < 4; k++) begin
      set_inputs(0, 0, 0, px[k], 40, 0, 0);
      clock_edge();
      checks++; if (wr_a !== 1'(aon[k])) begin errors++; $display("[TB] FAIL step_on_a[%0d] got %0d expected %0d", k, wr_a, aon[k]); end
      checks++; if (addr_a !== 18'(aad[k])) begin errors++; $display("[TB] FAIL step_addr_a[%0d] got %0d expected %0d", k, addr_a, aad[k]); end
      checks++; if (wr_b !== 1'(bon[k])) begin errors++; $display("[TB] FAIL step_on_b[%0d] got %0d expected %0d", k, wr_b, bon[k]); end
    end
    set_inputs(0, 0, 0, 636, 40, 0, 0);
    clock_edge();
    checks++; if (wr_b !== 1'b0) begin errors++; $display("[TB] FAIL step_left_b got %0d expected 0", wr_b); end
  endtask

  // Left-edge clipping and respawn of the single sprite.
  task automatic test_wrap();
    int ey;
    run_ticks(641, 1);
    set_inputs(0, 0, 0, 0, 40, 81, 40);
    #1;
    checks++; if (dr_a !== 1'b1) begin errors++; $display("[TB] FAIL clip_dr_in got %0d expected 1", dr_a); end
    checks++; if (dr_b !== exp_dr[1]) begin errors++; $display("[TB] FAIL clip_dr_b got %0d expected %0d", dr_b, exp_dr[1]); end
    clock_edge();
    checks++; if (addr_a !== 18'(BASE + 10)) begin errors++; $display("[TB] FAIL clip_addr got %0d expected %0d", addr_a, BASE + 10); end
    set_inputs(0, 0, 0, 0, 0, 82, 40);
    #1;
    checks++; if (dr_a !== 1'b0) begin errors++; $display("[TB] FAIL clip_dr_out got %0d expected 0", dr_a); end
    clock_edge();
    run_ticks(82, 1);
    set_inputs(0, 0, 0, 0, 40, 0, 40);
    #1;
    checks++; if (dr_a !== 1'b0) begin errors++; $display("[TB] FAIL offscreen_dr got %0d expected 0", dr_a); end
    clock_edge();
    checks++; if (wr_a !== 1'b0) begin errors++; $display("[TB] FAIL offscreen_wr got %0d expected 0", wr_a); end
    ey = 40 + (lfsr & 63);
    run_ticks(1, 1);
    set_inputs(0, 0, 0, 640, ey, 640, ey - 1);
    #1;
    checks++; if (dr_a !== 1'b0) begin errors++; $display("[TB] FAIL respawn_above got %0d expected 0", dr_a); end
    clock_edge();
    checks++; if (wr_a !== 1'b1) begin errors++; $display("[TB] FAIL respawn_on got %0d expected 1", wr_a); end
    checks++; if (addr_a !== 18'(BASE)) begin errors++; $display("[TB] FAIL respawn_addr got %0d expected %0d", addr_a, BASE); end
  endtask

  // Random frames, pauses and coordinates (biased towards live sprites) against the model.
  task automatic test_random();
    int x, y, ddx, ddy, d, s;
    for (int n = 0; n < 6000; n++) begin
      d = $urandom_range(1, 0);
      s = $urandom_range(ns[d] - 1, 0);
      if ($urandom_range(3, 0) != 0) begin
        x = clamp(mpx[d][s] + int'($urandom_range(SW + 4, 0)) - 2);
        y = clamp(mpy[d][s] + int'($urandom_range(SH + 4, 0)) - 2);
      end else begin
        x = $urandom_range(1023, 0);
        y = $urandom_range(200, 0);
      end
      ddx = clamp(x + int'($urandom_range(6, 0)) - 3);
      ddy = clamp(y + int'($urandom_range(6, 0)) - 3);
      set_inputs(0, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0), x, y, ddx, ddy);
      #1;
      checks++; if (dr_a !== exp_dr[0]) begin errors++; $display("[TB] FAIL rnd_dr_a@%0d got %0d expected %0d", n, dr_a, exp_dr[0]); end
      checks++; if (dr_b !== exp_dr[1]) begin errors++; $display("[TB] FAIL rnd_dr_b@%0d got %0d expected %0d", n, dr_b, exp_dr[1]); end
      clock_edge();
      checks++; if (wr_a !== exp_wr[0]) begin errors++; $display("[TB] FAIL rnd_wr_a@%0d got %0d expected %0d", n, wr_a, exp_wr[0]); end
      checks++; if (addr_a !== 18'(exp_addr[0])) begin errors++; $display("[TB] FAIL rnd_addr_a@%0d got %0d expected %0d", n, addr_a, exp_addr[0]); end
      checks++; if (idx_a !== 3'(exp_idx[0])) begin errors++; $display("[TB] FAIL rnd_idx_a@%0d got %0d expected %0d", n, idx_a, exp_idx[0]); end
      checks++; if (wr_b !== exp_wr[1]) begin errors++; $display("[TB] FAIL rnd_wr_b@%0d got %0d expected %0d", n, wr_b, exp_wr[1]); end
      checks++; if (addr_b !== 18'(exp_addr[1])) begin errors++; $display("[TB] FAIL rnd_addr_b@%0d got %0d expected %0d", n, addr_b, exp_addr[1]); end
      checks++; if (idx_b !== 3'(exp_idx[1])) begin errors++; $display("[TB] FAIL rnd_idx_b@%0d got %0d expected %0d", n, idx_b, exp_idx[1]); end
    end
  endtask

  // One-cycle reset in the middle of scrolling restores positions, outputs and LFSR.
  task automatic test_mid_reset();
    int ey;
    set_inputs(1, 1, 1, clamp(mpx[1][0] + 5), clamp(mpy[1][0] + 5), 0, 0);
    clock_edge();
    checks++; if (wr_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_wr_a got %0d expected 0", wr_a); end
    checks++; if (wr_b !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_wr_b got %0d expected 0", wr_b); end
    checks++; if (addr_b !== 18'(BASE)) begin errors++; $display("[TB] FAIL mid_reset_addr_b got %0d expected %0d", addr_b, BASE); end
    checks++; if (idx_b !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset_idx_b got %0d expected 0", idx_b); end
    set_inputs(0, 0, 0, 641, 70, 640, 40);
    #1;
    checks++; if (dr_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_dr got %0d expected 1", dr_a); end
    clock_edge();
    checks++; if (wr_b !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_on_b got %0d expected 1", wr_b); end
    checks++; if (idx_b !== 3'd1) begin errors++; $display("[TB] FAIL mid_reset_idx1 got %0d expected 1", idx_b); end
    checks++; if (addr_b !== 18'(45709)) begin errors++; $display("[TB] FAIL mid_reset_addr1 got %0d expected 45709", addr_b); end
    run_ticks(732, 1);
    ey = 40 + (lfsr & 63);
    run_ticks(1, 1);
    set_inputs(0, 0, 0, 640, ey, 0, 0);
    clock_edge();
    checks++; if (wr_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_respawn_on got %0d expected 1", wr_a); end
    checks++; if (addr_a !== 18'(BASE)) begin errors++; $display("[TB] FAIL mid_reset_respawn_addr got %0d expected %0d", addr_a, BASE); end
  endtask

  initial begin
    lfsr = 'hACE1;
    set_inputs(1, 0, 0, 1023, 1023, 1023, 1023);
    $display("[TB] starting sprite_scroller bench");
    test_reset();
    test_write_path();
    test_pause();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
